// File: rtl/craft_encrypt_scheduler_pkg.sv
// +----------------------------------------------------------------------------+
// | craft_encrypt_scheduler_pkg : shared widths, FSM encoding, helper function  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package craft_encrypt_scheduler_pkg;

   localparam int CRAFT_BLK_W = 64;
   localparam int CRAFT_KEY_W = 128;
   localparam int CRAFT_TWK_W = 64;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_START = 4'b0010,
      ST_RUN   = 4'b0100,
      ST_RESP  = 4'b1000
   } sched_state_e;

   // Requester index width; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/craft_encrypt_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | craft_encrypt_scheduler_if : request/response bus between clients and the   |
// | scheduler. Revision 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface craft_encrypt_scheduler_if #(
   parameter int NUM_REQ = 4
) ();
   import craft_encrypt_scheduler_pkg::*;

   localparam int IDW = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ*CRAFT_BLK_W-1:0] req_plaintext;
   logic [NUM_REQ*CRAFT_TWK_W-1:0] req_tweak;
   logic [NUM_REQ*CRAFT_KEY_W-1:0] req_key;
   logic                           rsp_valid;
   logic                           rsp_ready;
   logic [IDW-1:0]                 rsp_id;
   logic [CRAFT_BLK_W-1:0]         rsp_ciphertext;
   logic                           rsp_error;

   modport master (
      output req_valid, req_plaintext, req_tweak, req_key, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_ciphertext, rsp_error
   );

   modport slave (
      input  req_valid, req_plaintext, req_tweak, req_key, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_ciphertext, rsp_error
   );

endinterface

`default_nettype wire

// File: rtl/craft_encrypt_scheduler_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | craft_encrypt_scheduler_rr_arbiter : combinational round-robin pick of the  |
// | first valid request at or after ptr. Revision 1.0                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module craft_encrypt_scheduler_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grant_idx,
   output logic               any_valid
);

   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end
      return IDW'(s);
   endfunction

   logic w_found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && req[wrap_idx(ptr, i)]) begin
            w_found   = 1'b1;
            grant_idx = wrap_idx(ptr, i);
         end
      end
      if (w_found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign any_valid = w_found;

endmodule

`default_nettype wire

// File: rtl/craft_encrypt_scheduler.sv
// +----------------------------------------------------------------------------+
// | craft_encrypt_scheduler : shares one CRAFT core among NUM_REQ requesters    |
// | with round-robin grant, reset-pulse start and tagged response. Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module craft_encrypt_scheduler
   import craft_encrypt_scheduler_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int RST_PULSE      = 2,
   parameter int TIMEOUT_CYCLES = 2047
) (
   input  logic                   clk,
   input  logic                   rst_n,
   craft_encrypt_scheduler_if.slave bus,
   output logic                   busy,
   output logic                   core_rst_n,
   output logic [CRAFT_BLK_W-1:0] core_plaintext,
   output logic [CRAFT_TWK_W-1:0] core_tweak,
   output logic [CRAFT_KEY_W-1:0] core_key,
   input  logic                   core_done,
   input  logic [CRAFT_BLK_W-1:0] core_ciphertext
);

   localparam int IDW = idx_width(NUM_REQ);
   localparam int PCW = $clog2(RST_PULSE + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PCW-1:0] C_PULSE_LAST = PCW'(RST_PULSE - 1);
   localparam logic [TCW-1:0] C_TMO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
   localparam logic [IDW-1:0] C_IDX_LAST   = IDW'(NUM_REQ - 1);

   logic [NUM_REQ-1:0] w_grant;
   logic [IDW-1:0]     w_grant_idx;
   logic               w_any_valid;

   sched_state_e           state_q, state_d;
   logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [PCW-1:0]         pcnt_q, pcnt_d;
   logic [TCW-1:0]         tcnt_q, tcnt_d;
   logic                   start_q, start_d;
   logic                   busy_q, busy_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]         rsp_id_q, rsp_id_d;
   logic [CRAFT_BLK_W-1:0] rsp_ct_q, rsp_ct_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [CRAFT_BLK_W-1:0] pt_q, pt_d;
   logic [CRAFT_TWK_W-1:0] tw_q, tw_d;
   logic [CRAFT_KEY_W-1:0] key_q, key_d;

   craft_encrypt_scheduler_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_arb (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_q),
      .grant     (w_grant),
      .grant_idx (w_grant_idx),
      .any_valid (w_any_valid)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      pcnt_d      = pcnt_q;
      tcnt_d      = tcnt_q;
      start_d     = start_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_ct_d    = rsp_ct_q;
      rsp_err_d   = rsp_err_q;
      pt_d        = pt_q;
      tw_d        = tw_q;
      key_d       = key_q;
      case (state_q)
         ST_IDLE: begin
            if (w_any_valid) begin
               pt_d     = bus.req_plaintext[CRAFT_BLK_W*int'(w_grant_idx) +: CRAFT_BLK_W];
               tw_d     = bus.req_tweak[CRAFT_TWK_W*int'(w_grant_idx) +: CRAFT_TWK_W];
               key_d    = bus.req_key[CRAFT_KEY_W*int'(w_grant_idx) +: CRAFT_KEY_W];
               rsp_id_d = w_grant_idx;
               rr_ptr_d = (w_grant_idx == C_IDX_LAST) ? '0 : w_grant_idx + 1'b1;
               pcnt_d   = '0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (pcnt_q == C_PULSE_LAST) begin
               start_d = 1'b1;
               tcnt_d  = '0;
               state_d = ST_RUN;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            // First RUN cycle may still see done left over from the previous run.
            if (core_done && (tcnt_q != '0)) begin
               rsp_ct_d    = core_ciphertext;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else if (tcnt_q == C_TMO_LAST) begin
               rsp_ct_d    = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               start_d     = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         pcnt_q      <= '0;
         tcnt_q      <= '0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_ct_q    <= '0;
         rsp_err_q   <= 1'b0;
         pt_q        <= '0;
         tw_q        <= '0;
         key_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         pcnt_q      <= pcnt_d;
         tcnt_q      <= tcnt_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_ct_q    <= rsp_ct_d;
         rsp_err_q   <= rsp_err_d;
         pt_q        <= pt_d;
         tw_q        <= tw_d;
         key_q       <= key_d;
      end
   end

   // Grant is combinational so the accept pulse lands in the same cycle as capture.
   assign bus.req_ready      = (state_q == ST_IDLE) ? (w_grant & {NUM_REQ{rst_n}}) : '0;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_id         = rsp_id_q;
   assign bus.rsp_ciphertext = rsp_ct_q;
   assign bus.rsp_error      = rsp_err_q;
   assign busy               = busy_q;
   assign core_rst_n         = rst_n & start_q;
   assign core_plaintext     = pt_q;
   assign core_tweak         = tw_q;
   assign core_key           = key_q;

endmodule

`default_nettype wire

// File: tb/tb_craft_encrypt_scheduler.sv
// Scoreboard bench for craft_encrypt_scheduler: directed requests against a stub core
// whose done timing (normal / never / stuck-high) is selectable per test.
`default_nettype none

module tb_craft_encrypt_scheduler;
   import craft_encrypt_scheduler_pkg::*;

   localparam int NREQ  = 4;
   localparam int PULSE = 2;
   localparam int TMO   = 16;
   localparam int LAT   = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   craft_encrypt_scheduler_if #(.NUM_REQ(NREQ)) bus ();

   logic         busy, core_rst_n, core_done;
   logic [63:0]  core_pt, core_tw, core_ct;
   logic [127:0] core_key;

   craft_encrypt_scheduler #(
      .NUM_REQ        (NREQ),
      .RST_PULSE      (PULSE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .busy            (busy),
      .core_rst_n      (core_rst_n),
      .core_plaintext  (core_pt),
      .core_tweak      (core_tw),
      .core_key        (core_key),
      .core_done       (core_done),
      .core_ciphertext (core_ct)
   );

   function automatic logic [63:0] stub_ct(input logic [63:0] pt, input logic [63:0] tw,
                                           input logic [127:0] k);
      return pt ^ tw ^ k[63:0] ^ {k[123:64], k[127:124]} ^ 64'hC0DEC0DEC0DEC0DE;
   endfunction

   function automatic logic [63:0] op_pt(input int i, input int k);
      return {16'(i), 16'(k), 32'h600DF00D};
   endfunction
   function automatic logic [63:0] op_tw(input int i, input int k);
      return {32'(k * 7 + i), 32'h0BADBEEF};
   endfunction
   function automatic logic [127:0] op_key(input int i, input int k);
      return {32'(i), 32'h01234567, 32'(k + 3), 32'hFEEDFACE};
   endfunction

   // Stub core: done a fixed number of cycles after its reset is released.
   int         core_mode = 0;
   logic [7:0] core_cnt;
   always_ff @(posedge clk or negedge core_rst_n) begin
      if (!core_rst_n) core_cnt <= '0;
      else if (core_cnt != 8'hff) core_cnt <= core_cnt + 8'd1;
   end
   assign core_done = (core_mode == 2) ? 1'b1 : (core_mode == 1) ? 1'b0 : (core_cnt >= 8'(LAT));
   assign core_ct   = stub_ct(core_pt, core_tw, core_key);

   typedef struct {
      int          id;
      logic [63:0] ct;
      logic        err;
      int          run;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [63:0] ct, input logic err, input int run);
      exp_t e;
      e.id = id; e.ct = ct; e.err = err; e.run = run;
      sb.push_back(e);
   endtask

   // Monitor: per-run timing trackers, hold-stability checks, scoreboard pops.
   int          cyc = 0;
   int          grant_cyc, first_cyc, pulse_cnt, run_cnt;
   bit          in_hold;
   logic [1:0]  h_id;
   logic [63:0] h_ct;
   logic        h_err;
   exp_t        mon_e;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         in_hold = 1'b0; pulse_cnt = 0; run_cnt = 0;
      end else begin
         if (bus.req_ready != '0) begin
            chk("grant_onehot", $onehot(bus.req_ready), 1);
            grant_cyc = cyc; pulse_cnt = 0; run_cnt = 0;
         end
         if (busy && !core_rst_n) pulse_cnt++;
         if (busy && core_rst_n && !bus.rsp_valid) run_cnt++;
         if (bus.rsp_valid) begin
            if (in_hold)
               chk("hold_stable", {bus.rsp_id, bus.rsp_ciphertext, bus.rsp_error, bus.req_ready, busy},
                   {h_id, h_ct, h_err, 4'b0000, 1'b1});
            else
               first_cyc = cyc;
            if (bus.rsp_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", bus.rsp_valid, 0);
               end else begin
                  mon_e = sb.pop_front();
                  chk("rsp_id", bus.rsp_id, mon_e.id);
                  chk("rsp_ct", bus.rsp_ciphertext, mon_e.ct);
                  chk("rsp_err", bus.rsp_error, mon_e.err);
                  chk("run_cycles", run_cnt, mon_e.run);
                  chk("pulse_cycles", pulse_cnt, PULSE);
                  chk("latency", first_cyc - grant_cyc, PULSE + mon_e.run + 1);
               end
               in_hold = 1'b0;
            end else begin
               in_hold = 1'b1;
               h_id = bus.rsp_id; h_ct = bus.rsp_ciphertext; h_err = bus.rsp_error;
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [63:0] pt, input logic [63:0] tw,
                          input logic [127:0] k);
      bus.req_plaintext[64*i +: 64] = pt;
      bus.req_tweak[64*i +: 64]     = tw;
      bus.req_key[128*i +: 128]     = k;
      bus.req_valid[i]              = 1'b1;
   endtask

   task automatic wait_grant(output int g);
      g = -1;
      for (int n = 0; n < 300 && g < 0; n++) begin
         @(negedge clk);
         for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) g = j;
      end
      if (g < 0) chk("grant_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(sb.size() == 0 && !busy) && n < 600) begin
         @(negedge clk); n++;
      end
      if (n >= 600) begin
         chk("idle_timeout", sb.size(), 0);
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_cond_rsp();
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 300) begin
         @(negedge clk); n++;
      end
      if (!bus.rsp_valid) chk("rsp_valid_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   int g;
   int jobs[NREQ];

   initial begin
      rst_n = 1'b0;
      bus.req_valid = '0; bus.req_plaintext = '0; bus.req_tweak = '0; bus.req_key = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_ct", bus.rsp_ciphertext, 0);
      chk("rst_rsp_err", bus.rsp_error, 0);
      chk("rst_core_rst_n", core_rst_n, 0);
      chk("rst_core_ops", {core_pt, core_tw}, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single request on port 2; tweak=key=0 so ct = pt ^ C0DE pattern.
      push(2, 64'hC1FD85B949750D31, 1'b0, LAT + 1);
      set_req(2, 64'h0123456789ABCDEF, 64'h0, 128'h0);
      wait_grant(g);
      chk("t1_grant", g, 2);
      bus.req_valid[2] = 1'b0;
      wait_idle();

      // All four valid for eight runs: strict rotation from pointer 0.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         jobs[i] = 0;
         set_req(i, op_pt(i, 0), op_tw(i, 0), op_key(i, 0));
      end
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NREQ; i++)
            push(i, stub_ct(op_pt(i, k), op_tw(i, k), op_key(i, k)), 1'b0, LAT + 1);
      for (int n = 0; n < 8; n++) begin
         wait_grant(g);
         chk("t2_order", g, n % NREQ);
         if (g >= 0) begin
            jobs[g]++;
            if (jobs[g] < 2) set_req(g, op_pt(g, 1), op_tw(g, 1), op_key(g, 1));
            else bus.req_valid[g] = 1'b0;
         end
      end
      wait_idle();

      // Backpressure with a competing request pending.
      bus.rsp_ready = 1'b0;
      push(1, stub_ct(op_pt(1, 5), op_tw(1, 5), op_key(1, 5)), 1'b0, LAT + 1);
      push(3, stub_ct(op_pt(3, 6), op_tw(3, 6), op_key(3, 6)), 1'b0, LAT + 1);
      set_req(1, op_pt(1, 5), op_tw(1, 5), op_key(1, 5));
      wait_grant(g);
      chk("t3_grant_a", g, 1);
      bus.req_valid[1] = 1'b0;
      set_req(3, op_pt(3, 6), op_tw(3, 6), op_key(3, 6));
      wait_cond_rsp();
      repeat (50) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      wait_grant(g);
      chk("t3_grant_b", g, 3);
      bus.req_valid[3] = 1'b0;
      wait_idle();

      // Core never finishes: error response after TMO RUN cycles.
      core_mode = 1;
      push(0, 64'h0, 1'b1, TMO);
      set_req(0, op_pt(0, 9), op_tw(0, 9), op_key(0, 9));
      wait_grant(g);
      chk("t4_grant", g, 0);
      bus.req_valid[0] = 1'b0;
      wait_idle();

      // Done stuck high: ignored in first RUN cycle, accepted in the second.
      core_mode = 2;
      push(1, stub_ct(op_pt(1, 11), op_tw(1, 11), op_key(1, 11)), 1'b0, 2);
      set_req(1, op_pt(1, 11), op_tw(1, 11), op_key(1, 11));
      wait_grant(g);
      chk("t5_grant", g, 1);
      bus.req_valid[1] = 1'b0;
      wait_idle();
      core_mode = 0;

      // Reset in the middle of RUN aborts silently.
      push(2, 64'h0, 1'b0, 0);
      set_req(2, op_pt(2, 13), op_tw(2, 13), op_key(2, 13));
      wait_grant(g);
      chk("t6_grant", g, 2);
      bus.req_valid[2] = 1'b0;
      for (int n = 0; n < 50 && !core_rst_n; n++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_async_ctl", {busy, bus.rsp_valid, core_rst_n, bus.req_ready}, 0);
      chk("t6_async_rsp", {bus.rsp_id, bus.rsp_ciphertext, bus.rsp_error}, 0);
      chk("t6_async_ops", {core_pt, core_tw, core_key}, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      push(2, stub_ct(op_pt(2, 14), op_tw(2, 14), op_key(2, 14)), 1'b0, LAT + 1);
      set_req(2, op_pt(2, 14), op_tw(2, 14), op_key(2, 14));
      wait_grant(g);
      chk("t6_regrant", g, 2);
      bus.req_valid[2] = 1'b0;
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule

`default_nettype wire
